// File: rtl/ob_pkg.sv
// Shared order-book types: table entries, ingress commands, responses and
// the install controller's state encoding.
package ob_pkg;

    localparam int UID_W   = 16;
    localparam int QTY_W   = 16;
    localparam int PRICE_W = 32;

    typedef struct packed {
        logic [UID_W-1:0]   uid;
        logic [QTY_W-1:0]   quantity;
        logic [PRICE_W-1:0] price;
    } table_t;

    typedef struct packed {
        logic   is_ask;
        table_t payload;
    } cmd_t;

    typedef enum logic [1:0] {
        INSTALLED = 2'd0,
        CROSS     = 2'd1,
        BADQTY    = 2'd2,
        REJECT    = 2'd3
    } status_e;

    typedef struct packed {
        logic             is_ask;
        logic [UID_W-1:0] uid;
        status_e          status;
    } rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DRAIN_WAIT
    } ctl_state_e;

    // A bid crosses a resting ask at or below its price; an ask crosses a bid at or above.
    function automatic logic orderCrosses(
        input logic               isAsk,
        input logic [PRICE_W-1:0] price,
        input logic               bidVld,
        input logic [PRICE_W-1:0] bidPrice,
        input logic               askVld,
        input logic [PRICE_W-1:0] askPrice
    );
        if (isAsk) begin
            return bidVld && (price <= bidPrice);
        end
        return askVld && (price >= askPrice);
    endfunction

endpackage

// File: rtl/ob_rsp_reg.sv
// Single-entry valid/ready holding register for the controller's response channel.
module ob_rsp_reg
    import ob_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  rsp_t i_rsp,
    input  logic i_rdy,
    output logic o_vld,
    output rsp_t o_rsp
);

    logic r_vld;
    rsp_t r_rsp;

    // A fresh load takes priority over the consumer draining the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_rsp <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_rsp <= i_rsp;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_rsp = r_rsp;

endmodule

// File: rtl/ob_install_ctl.sv
// Order-ingress controller: checks each new order against the opposing book
// head, installs it into the bid or ask table, and drains table rejects.
module ob_install_ctl
    import ob_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit ALLOW_CROSS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    input  cmd_t             cmd,
    output logic             cmd_rdy,
    input  logic             bid_head_vld_r,
    input  table_t           bid_head_r,
    input  logic             ask_head_vld_r,
    input  table_t           ask_head_r,
    output logic             bid_install_vld,
    output table_t           bid_install,
    output logic             ask_install_vld,
    output table_t           ask_install,
    input  logic             bid_reject_valid_r,
    input  logic             ask_reject_valid_r,
    output logic             bid_reject_pop,
    output logic             ask_reject_pop,
    output logic             rsp_vld_r,
    output rsp_t             rsp_r,
    input  logic             rsp_rdy,
    output logic [CNT_W-1:0] install_cnt_r,
    output logic [CNT_W-1:0] reject_cnt_r
);

    ctl_state_e       r_state;
    ctl_state_e       w_next_state;
    cmd_t             r_ord;
    logic             r_drain_ask;
    logic [CNT_W-1:0] r_install_cnt;
    logic [CNT_W-1:0] r_reject_cnt;

    logic w_slot_free;
    logic w_cmd_rdy;
    logic w_accept;
    logic w_start_drain;
    logic w_issue;
    logic w_drain;
    logic w_cross;
    logic w_rsp_load;
    rsp_t w_rsp;
    logic w_unused_heads;

    // Only the head prices matter for the cross test.
    assign w_unused_heads = ^{bid_head_r.uid, bid_head_r.quantity,
                              ask_head_r.uid, ask_head_r.quantity};

    assign w_slot_free = !rsp_vld_r || rsp_rdy;
    assign w_cross = orderCrosses(r_ord.is_ask, r_ord.payload.price,
                                  bid_head_vld_r, bid_head_r.price,
                                  ask_head_vld_r, ask_head_r.price);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_cmd_rdy     = 1'b0;
        w_accept      = 1'b0;
        w_start_drain = 1'b0;
        w_issue       = 1'b0;
        w_drain       = 1'b0;
        w_rsp_load    = 1'b0;
        w_rsp         = '0;
        case (r_state)
            ST_IDLE: begin
                if ((bid_reject_valid_r || ask_reject_valid_r) && w_slot_free) begin
                    w_start_drain = 1'b1;
                    w_next_state  = ST_DRAIN;
                end else begin
                    w_cmd_rdy = 1'b1;
                    if (cmd_vld) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                if (w_slot_free) begin
                    w_rsp.is_ask = r_ord.is_ask;
                    w_rsp.uid    = r_ord.payload.uid;
                    if (r_ord.payload.quantity == '0) begin
                        w_rsp.status = BADQTY;
                        w_rsp_load   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else if (w_cross && !ALLOW_CROSS) begin
                        w_rsp.status = CROSS;
                        w_rsp_load   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_rsp.is_ask = r_ord.is_ask;
                w_rsp.uid    = r_ord.payload.uid;
                w_rsp.status = INSTALLED;
                w_rsp_load   = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                w_drain      = 1'b1;
                w_rsp.is_ask = r_drain_ask;
                w_rsp.status = REJECT;
                w_rsp_load   = 1'b1;
                w_next_state = ST_DRAIN_WAIT;
            end
            ST_DRAIN_WAIT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Order capture, drained-side choice (bid wins ties) and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ord         <= '0;
            r_drain_ask   <= 1'b0;
            r_install_cnt <= '0;
            r_reject_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_ord <= cmd;
            end
            if (w_start_drain) begin
                r_drain_ask <= !bid_reject_valid_r;
            end
            if (w_issue) begin
                r_install_cnt <= r_install_cnt + CNT_W'(1);
            end
            if (w_drain) begin
                r_reject_cnt <= r_reject_cnt + CNT_W'(1);
            end
        end
    end

    ob_rsp_reg u_rsp_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_rsp_load),
        .i_rsp  (w_rsp),
        .i_rdy  (rsp_rdy),
        .o_vld  (rsp_vld_r),
        .o_rsp  (rsp_r)
    );

    // Strobes are masked while rst is high so a reset cycle never commits anything.
    assign cmd_rdy         = w_cmd_rdy && !rst;
    assign bid_install_vld = w_issue && !r_ord.is_ask && !rst;
    assign ask_install_vld = w_issue && r_ord.is_ask && !rst;
    assign bid_install     = r_ord.payload;
    assign ask_install     = r_ord.payload;
    assign bid_reject_pop  = w_drain && !r_drain_ask && !rst;
    assign ask_reject_pop  = w_drain && r_drain_ask && !rst;
    assign install_cnt_r   = r_install_cnt;
    assign reject_cnt_r    = r_reject_cnt;

endmodule
